uart_tx_queue: RTL and testbench

- Downstream output stage of the multi-cycle CPU.
- Accepts bytes pushed by the EX stage when it executes PRINTI/PRINTC, one byte per push, MSB byte of a word first, and buffers them in a circular FIFO.
- Serialises the buffered bytes onto the board UART TX pin as 8N1 frames at a fixed baud.
- Decouples CPU execution from line rate; the CPU stalls on FULL.

---
 rtl/uart_tx_queue_if.sv | 23 ++
 rtl/uart_tx_queue.sv | 149 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Push-side handshake and status/serial outputs of the UART transmit queue.
interface uart_tx_queue_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              WR_EN;
  logic [7:0]        WR_DATA;
  logic              FULL;
  logic              EMPTY;
  logic [ADDR_W:0]   COUNT;
  logic              OVERFLOW;
  logic              BUSY;
  logic              UART_TX;

  modport master (
    output WR_EN, WR_DATA,
    input  FULL, EMPTY, COUNT, OVERFLOW, BUSY, UART_TX
  );

  modport slave (
    input  WR_EN, WR_DATA,
    output FULL, EMPTY, COUNT, OVERFLOW, BUSY, UART_TX
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO between the CPU print path and an 8N1 UART transmitter.
// The transmitter pops only on its IDLE->START transition.
module uart_tx_queue #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic              CLK,
  input  logic              INITIALIZE_N,
  uart_tx_queue_if.slave    bus
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [DEPTH];

  logic bit_end;
  logic push;
  logic pop;

  assign bit_end = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign pop     = (state_q == IDLE) && !empty_q;
  assign push    = bus.WR_EN && !full_q;

  // Full/overflow decisions use the pre-edge FULL, so a pop never rescues a push.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == CW'(0));
    overflow_d = overflow_q | (bus.WR_EN & full_q);
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.WR_DATA;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_q) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serializer datapath and registered line/busy outputs
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    if (state_q != IDLE) cnt_d = bit_end ? CNT_W'(0) : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(0);
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shreg_q[0];
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) busy_d = 1'b0;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.FULL     = full_q;
  assign bus.EMPTY    = empty_q;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.BUSY     = busy_q;
  assign bus.UART_TX  = tx_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with DEPTH=4, CLK_PER_BIT=4.
// A line monitor decodes 8N1 frames from UART_TX into a byte queue.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CPB    = 4;

  logic CLK;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLK_PER_BIT(CPB)) dut (
    .CLK          (CLK),
    .INITIALIZE_N (rst_n),
    .bus          (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  logic [7:0] rx_q [$];
  bit         ok_q [$];
  int         start_q [$];

  bit         mon_act = 1'b0;
  bit         mon_ok  = 1'b1;
  int         mon_ph  = 0;
  logic [7:0] mon_sh  = 8'h00;

  // Samples each bit in the middle of its period, counted from the start-bit detect.
  always @(negedge CLK) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (bus.UART_TX == 1'b0) begin
        mon_act = 1'b1;
        mon_ph  = 0;
        mon_ok  = 1'b1;
        start_q.push_back(cyc);
      end
    end else begin
      mon_ph++;
      if (mon_ph == 2 && bus.UART_TX !== 1'b0) mon_ok = 1'b0;
      if (mon_ph >= 6 && mon_ph <= 34 && ((mon_ph - 6) % 4) == 0)
        mon_sh[3'((mon_ph - 6) / 4)] = bus.UART_TX;
      if (mon_ph == 38) begin
        if (bus.UART_TX !== 1'b1) mon_ok = 1'b0;
        rx_q.push_back(mon_sh);
        ok_q.push_back(mon_ok);
        mon_act = 1'b0;
      end
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_empty;
    logic [2:0] exp_count;
  } vec_t;

  vec_t       vec [43];
  logic [9:0] fb;
  logic [7:0] t5 [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = b;
    step();
    bus.WR_EN   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.BUSY || !bus.EMPTY) && k < 600) begin
      step();
      k++;
    end
    step();
  endtask

  task automatic clear_rx();
    rx_q.delete();
    ok_q.delete();
    start_q.delete();
  endtask

  initial begin
    // Frame for 0xA5: start 0, data LSB first, stop 1
    fb = {1'b1, 8'hA5, 1'b0};
    vec[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd1};
    for (int j = 1; j <= 40; j++)
      vec[j] = '{1'b0, 8'h00, fb[(j - 1) / 4], 1'b1, 1'b1, 3'd0};
    vec[41] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
    vec[42] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0};
    t5 = '{8'h01, 8'h80, 8'h7E, 8'hC0, 8'h3F, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'hE7};

    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    rst_n       = 1'b0;
    #23 rst_n   = 1'b1;
    step();

    chk("rst_tx",       32'(bus.UART_TX),  32'd1);
    chk("rst_busy",     32'(bus.BUSY),     32'd0);
    chk("rst_empty",    32'(bus.EMPTY),    32'd1);
    chk("rst_full",     32'(bus.FULL),     32'd0);
    chk("rst_count",    32'(bus.COUNT),    32'd0);
    chk("rst_overflow", 32'(bus.OVERFLOW), 32'd0);

    // Single 0xA5 frame, cycle by cycle
    clear_rx();
    for (int j = 0; j < 43; j++) begin
      bus.WR_EN   = vec[j].wr_en;
      bus.WR_DATA = vec[j].wr_data;
      step();
      chk($sformatf("t1_tx[%0d]", j),    32'(bus.UART_TX), 32'(vec[j].exp_tx));
      chk($sformatf("t1_busy[%0d]", j),  32'(bus.BUSY),    32'(vec[j].exp_busy));
      chk($sformatf("t1_empty[%0d]", j), 32'(bus.EMPTY),   32'(vec[j].exp_empty));
      chk($sformatf("t1_count[%0d]", j), 32'(bus.COUNT),   32'(vec[j].exp_count));
    end
    bus.WR_EN = 1'b0;
    wait_rx(1, 10, "t1_rx_n");
    chk("t1_byte", 32'(rx_q[0]), 32'h0000_00A5);

    // Four back-to-back pushes
    wait_idle();
    clear_rx();
    push(8'h00); chk("t2_count0", 32'(bus.COUNT), 32'd1);
    push(8'h41); chk("t2_count1", 32'(bus.COUNT), 32'd1);
    push(8'h42); chk("t2_count2", 32'(bus.COUNT), 32'd2);
    push(8'hFF); chk("t2_count3", 32'(bus.COUNT), 32'd3);
    wait_rx(4, 250, "t2_rx_n");
    chk("t2_b0", 32'(rx_q[0]), 32'h00);
    chk("t2_b1", 32'(rx_q[1]), 32'h41);
    chk("t2_b2", 32'(rx_q[2]), 32'h42);
    chk("t2_b3", 32'(rx_q[3]), 32'hFF);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_spacing[%0d]", i), 32'(start_q[i + 1] - start_q[i]), 32'd41);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_frame_ok[%0d]", i), 32'(ok_q[i]), 32'd1);
    chk("t2_empty", 32'(bus.EMPTY), 32'd1);

    // Fill while a frame is in flight, then overflow
    wait_idle();
    clear_rx();
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    push(8'h14);
    chk("t3_full",  32'(bus.FULL),  32'd1);
    chk("t3_count", 32'(bus.COUNT), 32'd4);
    push(8'h99);
    chk("t3_full_after",  32'(bus.FULL),     32'd1);
    chk("t3_count_after", 32'(bus.COUNT),    32'd4);
    chk("t3_overflow",    32'(bus.OVERFLOW), 32'd1);
    step();
    chk("t3_overflow_sticky", 32'(bus.OVERFLOW), 32'd1);

    // Push on the pop edge while FULL is rejected
    begin
      int k;
      k = 0;
      while (bus.BUSY && k < 100) begin
        step();
        k++;
      end
    end
    chk("t4_idle_seen", 32'(bus.BUSY), 32'd0);
    push(8'h77);
    chk("t4_count",    32'(bus.COUNT),    32'd3);
    chk("t4_full",     32'(bus.FULL),     32'd0);
    chk("t4_busy",     32'(bus.BUSY),     32'd1);
    chk("t4_overflow", 32'(bus.OVERFLOW), 32'd1);
    push(8'h78);
    chk("t4_count2", 32'(bus.COUNT), 32'd4);
    chk("t4_full2",  32'(bus.FULL),  32'd1);
    wait_rx(6, 400, "t4_rx_n");
    chk("t4_b0", 32'(rx_q[0]), 32'h10);
    chk("t4_b1", 32'(rx_q[1]), 32'h11);
    chk("t4_b2", 32'(rx_q[2]), 32'h12);
    chk("t4_b3", 32'(rx_q[3]), 32'h13);
    chk("t4_b4", 32'(rx_q[4]), 32'h14);
    chk("t4_b5", 32'(rx_q[5]), 32'h78);

    // Ten bytes through a 4-deep FIFO, honouring FULL
    wait_idle();
    clear_rx();
    for (int i = 0; i < 10; i++) begin
      int k;
      k = 0;
      while (bus.FULL && k < 400) begin
        step();
        k++;
      end
      push(t5[i]);
    end
    wait_rx(10, 600, "t5_rx_n");
    for (int i = 0; i < 10; i++)
      chk($sformatf("t5_b[%0d]", i), 32'(rx_q[i]), 32'(t5[i]));
    chk("t5_overflow_kept", 32'(bus.OVERFLOW), 32'd1);

    // Asynchronous reset during data bit 3 of 0xC3, with 0x5A queued
    wait_idle();
    clear_rx();
    push(8'hC3);
    push(8'h5A);
    for (int j = 2; j <= 18; j++) step();
    chk("t6_tx_before", 32'(bus.UART_TX), 32'd0);
    chk("t6_busy_before", 32'(bus.BUSY), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_async",  32'(bus.UART_TX),  32'd1);
    chk("t6_busy",      32'(bus.BUSY),     32'd0);
    chk("t6_count",     32'(bus.COUNT),    32'd0);
    chk("t6_empty",     32'(bus.EMPTY),    32'd1);
    chk("t6_overflow",  32'(bus.OVERFLOW), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #3 rst_n = 1'b1;
    begin
      int lows;
      lows = 0;
      for (int j = 0; j < 60; j++) begin
        step();
        if (bus.UART_TX !== 1'b1 || bus.BUSY !== 1'b0) lows++;
      end
      chk("t6_quiet_after_reset", 32'(lows), 32'd0);
    end
    chk("t6_no_frames", 32'(rx_q.size()), 32'd0);
    push(8'h3C);
    wait_rx(1, 60, "t6_rx_n");
    chk("t6_new_byte", 32'(rx_q[0]), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
